net_iso_multi_reg_file: RTL and testbench

//  AXI-Lite control/status register file for a NUM_CH-channel AXI-Stream isolation core.
//  Per channel it holds decouple control, protocol-verifier status/clear, and BW-shaper tokens.

---
 rtl/net_iso_multi_reg_file.sv | 362 ++++++++++++++++++++++++++++++++++++
 tb/tb_net_iso_multi_reg_file.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_iso_multi_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : net_iso_multi_reg_file
// Description : AXI-Lite control/status register file for a NUM_CH-channel
//               AXI-Stream isolation core. Each channel has decouple control,
//               protocol-verifier status/clear with W1C sticky bits and
//               interrupt enables, and bandwidth-shaper token settings.
//               The AW and W channels are accepted independently, byte
//               strobes are honoured, and unmapped accesses return SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module net_iso_multi_reg_file #(
    parameter int NUM_CH                 = 4,
    parameter int TOKEN_COUNT_INT_WIDTH  = 16,
    parameter int TOKEN_COUNT_FRAC_WIDTH = 8,
    parameter int ADDR_WIDTH             = 12
) (
    input  logic                                           aclk,
    input  logic                                           areset,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]                          awaddr,
    input  logic                                           awvalid,
    output logic                                           awready,
    // write data channel
    input  logic [31:0]                                    wdata,
    input  logic [3:0]                                     wstrb,
    input  logic                                           wvalid,
    output logic                                           wready,
    // write response channel
    output logic [1:0]                                     bresp,
    output logic                                           bvalid,
    input  logic                                           bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]                          araddr,
    input  logic                                           arvalid,
    output logic                                           arready,
    // read data channel
    output logic [31:0]                                    rdata,
    output logic [1:0]                                     rresp,
    output logic                                           rvalid,
    input  logic                                           rready,
    // per-channel isolation core interface
    output logic [NUM_CH-1:0]                              decouple,
    input  logic [NUM_CH-1:0]                              decouple_done,
    input  logic [2*NUM_CH-1:0]                            decouple_status_vector,
    input  logic [NUM_CH-1:0]                              oversize_error_irq,
    output logic [NUM_CH-1:0]                              oversize_error_clear,
    input  logic [NUM_CH-1:0]                              timeout_error_irq,
    output logic [NUM_CH-1:0]                              timeout_error_clear,
    output logic [NUM_CH*TOKEN_COUNT_INT_WIDTH-1:0]        init_token,
    output logic [NUM_CH*(TOKEN_COUNT_FRAC_WIDTH+1)-1:0]   upd_token,
    output logic                                           irq
);

    localparam int c_int_w = TOKEN_COUNT_INT_WIDTH;
    localparam int c_upd_w = TOKEN_COUNT_FRAC_WIDTH + 1;
    localparam int c_ch_aw = ADDR_WIDTH - 4;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    localparam logic [1:0] c_off_dec  = 2'd0;
    localparam logic [1:0] c_off_ver  = 2'd1;
    localparam logic [1:0] c_off_init = 2'd2;
    localparam logic [1:0] c_off_upd  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_id_addr  = ADDR_WIDTH'(12'hFFC);
    localparam logic [31:0]           c_id_value = {16'h4E49, 8'd2, 8'(NUM_CH)};

    // ------------------------------------------------------------------------
    // Byte-lane merge: replace the bytes of cur selected by strb with data.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] f_merge(input logic [31:0] cur,
                                            input logic [31:0] data,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------------
    logic                  r_aw_full;
    logic                  r_awready;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_full;
    logic                  r_wready;
    logic [31:0]           r_w_data;
    logic [3:0]            r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_aw_full_nxt;
    logic                  w_w_full_nxt;
    logic [c_ch_aw-1:0]    w_wr_ch;
    logic [1:0]            w_wr_off;
    logic                  w_wr_is_id;
    logic                  w_wr_ch_ok;
    logic                  w_wr_mapped;

    // ------------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------------
    logic                  r_arready;
    logic                  r_ar_pending;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_ar_hs;
    logic                  w_rvalid_nxt;
    logic                  w_arready_nxt;
    logic [c_ch_aw-1:0]    w_rd_ch;
    logic [1:0]            w_rd_off;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;

    // ------------------------------------------------------------------------
    // Per-channel registers
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0]     r_decouple;
    logic [NUM_CH-1:0]     r_ovs_clear;
    logic [NUM_CH-1:0]     r_tmo_clear;
    logic [NUM_CH-1:0]     r_ovs_sticky;
    logic [NUM_CH-1:0]     r_tmo_sticky;
    logic [NUM_CH-1:0]     r_ovs_en;
    logic [NUM_CH-1:0]     r_tmo_en;
    logic [c_int_w-1:0]    r_init [NUM_CH];
    logic [c_upd_w-1:0]    r_upd  [NUM_CH];
    logic                  r_irq;

    logic [NUM_CH-1:0]     w_dec_wr;
    logic [NUM_CH-1:0]     w_ver_wr;
    logic [NUM_CH-1:0]     w_init_wr;
    logic [NUM_CH-1:0]     w_upd_wr;

    logic                  w_unused;

    // ------------------------------------------------------------------------
    // Write-side handshakes, commit condition and address decode
    // ------------------------------------------------------------------------
    assign w_aw_hs       = awvalid & r_awready;
    assign w_w_hs        = wvalid & r_wready;
    assign w_commit      = r_aw_full & r_w_full & ~r_bvalid;
    assign w_aw_full_nxt = w_commit ? 1'b0 : (r_aw_full | w_aw_hs);
    assign w_w_full_nxt  = w_commit ? 1'b0 : (r_w_full | w_w_hs);

    assign w_wr_ch     = r_aw_addr[ADDR_WIDTH-1:4];
    assign w_wr_off    = r_aw_addr[3:2];
    assign w_wr_is_id  = (r_aw_addr == c_id_addr);
    assign w_wr_ch_ok  = (32'(w_wr_ch) < NUM_CH);
    assign w_wr_mapped = w_wr_ch_ok | w_wr_is_id;

    // Buffer AW and W independently; commit once both are held and no response is outstanding
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_aw_full <= 1'b0;
            r_awready <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_wready  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_wready  <= ~w_w_full_nxt;
            if (w_aw_hs) begin
                r_aw_addr <= awaddr;
            end
            if (w_w_hs) begin
                r_w_data <= wdata;
                r_w_strb <= wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_mapped ? c_resp_okay : c_resp_slverr;
            end else if (bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Decode the committed write into per-channel, per-register strobes
    always_comb begin
        w_dec_wr  = '0;
        w_ver_wr  = '0;
        w_init_wr = '0;
        w_upd_wr  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_commit && (32'(w_wr_ch) == 32'(c))) begin
                w_dec_wr[c]  = (w_wr_off == c_off_dec) & r_w_strb[0];
                w_ver_wr[c]  = (w_wr_off == c_off_ver) & r_w_strb[0];
                w_init_wr[c] = (w_wr_off == c_off_init);
                w_upd_wr[c]  = (w_wr_off == c_off_upd);
            end
        end
    end

    // Per-channel control, sticky status (raw set beats W1C) and token registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_decouple   <= '0;
            r_ovs_clear  <= '0;
            r_tmo_clear  <= '0;
            r_ovs_sticky <= '0;
            r_tmo_sticky <= '0;
            r_ovs_en     <= '0;
            r_tmo_en     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_init[c] <= '0;
                r_upd[c]  <= '0;
            end
        end else begin
            r_tmo_clear <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_dec_wr[c]) begin
                    r_decouple[c] <= r_w_data[0];
                end
                if (w_ver_wr[c]) begin
                    r_ovs_clear[c] <= r_w_data[0];
                    r_tmo_clear[c] <= r_w_data[1];
                    r_ovs_en[c]    <= r_w_data[4];
                    r_tmo_en[c]    <= r_w_data[5];
                end
                if (oversize_error_irq[c]) begin
                    r_ovs_sticky[c] <= 1'b1;
                end else if (w_ver_wr[c] && r_w_data[2]) begin
                    r_ovs_sticky[c] <= 1'b0;
                end
                if (timeout_error_irq[c]) begin
                    r_tmo_sticky[c] <= 1'b1;
                end else if (w_ver_wr[c] && r_w_data[3]) begin
                    r_tmo_sticky[c] <= 1'b0;
                end
                if (w_init_wr[c]) begin
                    r_init[c] <= c_int_w'(f_merge(32'(r_init[c]), r_w_data, r_w_strb));
                end
                if (w_upd_wr[c]) begin
                    r_upd[c] <= c_upd_w'(f_merge(32'(r_upd[c]), r_w_data, r_w_strb));
                end
            end
        end
    end

    // Summary interrupt: any enabled sticky status across all channels
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((r_ovs_sticky & r_ovs_en) | (r_tmo_sticky & r_tmo_en));
        end
    end

    // ------------------------------------------------------------------------
    // Read path: one address in flight, data registered one cycle after AR
    // ------------------------------------------------------------------------
    assign w_ar_hs       = arvalid & r_arready;
    assign w_rvalid_nxt  = r_ar_pending | (r_rvalid & ~rready);
    assign w_arready_nxt = ~w_rvalid_nxt & ~w_ar_hs;

    assign w_rd_ch  = r_ar_addr[ADDR_WIDTH-1:4];
    assign w_rd_off = r_ar_addr[3:2];

    // Select read data for the captured address; unmapped returns zero with SLVERR
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_resp_slverr;
        if (r_ar_addr == c_id_addr) begin
            w_rd_data = c_id_value;
            w_rd_resp = c_resp_okay;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (32'(w_rd_ch) == 32'(c)) begin
                    w_rd_resp = c_resp_okay;
                    case (w_rd_off)
                        c_off_dec: begin
                            w_rd_data[0]   = r_decouple[c];
                            w_rd_data[1]   = decouple_done[c];
                            w_rd_data[3:2] = decouple_status_vector[2*c +: 2];
                        end
                        c_off_ver: begin
                            w_rd_data[0] = r_ovs_clear[c];
                            w_rd_data[2] = r_ovs_sticky[c];
                            w_rd_data[3] = r_tmo_sticky[c];
                            w_rd_data[4] = r_ovs_en[c];
                            w_rd_data[5] = r_tmo_en[c];
                            w_rd_data[6] = oversize_error_irq[c];
                            w_rd_data[7] = timeout_error_irq[c];
                        end
                        c_off_init: w_rd_data = 32'(r_init[c]);
                        default:    w_rd_data = 32'(r_upd[c]);
                    endcase
                end
            end
        end
    end

    // Accept AR, then present registered data until the master takes it
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_arready    <= 1'b0;
            r_ar_pending <= 1'b0;
            r_ar_addr    <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= c_resp_okay;
        end else begin
            r_arready    <= w_arready_nxt;
            r_ar_pending <= w_ar_hs;
            r_rvalid     <= w_rvalid_nxt;
            if (w_ar_hs) begin
                r_ar_addr <= araddr;
            end
            if (r_ar_pending) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign awready              = r_awready;
    assign wready               = r_wready;
    assign bvalid               = r_bvalid;
    assign bresp                = r_bresp;
    assign arready              = r_arready;
    assign rvalid               = r_rvalid;
    assign rdata                = r_rdata;
    assign rresp                = r_rresp;
    assign decouple             = r_decouple;
    assign oversize_error_clear = r_ovs_clear;
    assign timeout_error_clear  = r_tmo_clear;
    assign irq                  = r_irq;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_token_pack
            assign init_token[g*c_int_w +: c_int_w] = r_init[g];
            assign upd_token[g*c_upd_w +: c_upd_w]  = r_upd[g];
        end
    endgenerate

    // Sub-word address bits carry no meaning for 32-bit registers
    assign w_unused = &{1'b0, r_aw_addr[1:0], r_ar_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_net_iso_multi_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_iso_multi_reg_file
// Description : Directed self-checking bench for net_iso_multi_reg_file with
//               a response scoreboard for B and R channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_iso_multi_reg_file;

    localparam int NUM_CH = 4;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 8;
    localparam int UPD_W  = FRAC_W + 1;
    localparam int AW     = 12;

    logic                      aclk;
    logic                      areset;
    logic [AW-1:0]             awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [31:0]               wdata;
    logic [3:0]                wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AW-1:0]             araddr;
    logic                      arvalid;
    logic                      arready;
    logic [31:0]               rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;
    logic [NUM_CH-1:0]         decouple;
    logic [NUM_CH-1:0]         decouple_done;
    logic [2*NUM_CH-1:0]       decouple_status_vector;
    logic [NUM_CH-1:0]         oversize_error_irq;
    logic [NUM_CH-1:0]         oversize_error_clear;
    logic [NUM_CH-1:0]         timeout_error_irq;
    logic [NUM_CH-1:0]         timeout_error_clear;
    logic [NUM_CH*INT_W-1:0]   init_token;
    logic [NUM_CH*UPD_W-1:0]   upd_token;
    logic                      irq;

    int n_pass  = 0;
    int n_total = 0;
    int clr_cycles = 0;
    logic [NUM_CH-1:0] clr_mask = '0;
    int clr_snap;

    logic [1:0]  q_bresp [$];
    logic [33:0] q_rd    [$];

    net_iso_multi_reg_file #(
        .NUM_CH                 (NUM_CH),
        .TOKEN_COUNT_INT_WIDTH  (INT_W),
        .TOKEN_COUNT_FRAC_WIDTH (FRAC_W),
        .ADDR_WIDTH             (AW)
    ) dut (
        .aclk                   (aclk),
        .areset                 (areset),
        .awaddr                 (awaddr),
        .awvalid                (awvalid),
        .awready                (awready),
        .wdata                  (wdata),
        .wstrb                  (wstrb),
        .wvalid                 (wvalid),
        .wready                 (wready),
        .bresp                  (bresp),
        .bvalid                 (bvalid),
        .bready                 (bready),
        .araddr                 (araddr),
        .arvalid                (arvalid),
        .arready                (arready),
        .rdata                  (rdata),
        .rresp                  (rresp),
        .rvalid                 (rvalid),
        .rready                 (rready),
        .decouple               (decouple),
        .decouple_done          (decouple_done),
        .decouple_status_vector (decouple_status_vector),
        .oversize_error_irq     (oversize_error_irq),
        .oversize_error_clear   (oversize_error_clear),
        .timeout_error_irq      (timeout_error_irq),
        .timeout_error_clear    (timeout_error_clear),
        .init_token             (init_token),
        .upd_token              (upd_token),
        .irq                    (irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count cycles in which any timeout clear pulse is high
    always @(negedge aclk) begin
        if (timeout_error_clear != '0) begin
            clr_cycles++;
            clr_mask |= timeout_error_clear;
        end
    end

    // Hard stop in case a handshake never completes
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_aw(input logic [AW-1:0] a);
        int n;
        n = 0;
        awaddr  = a;
        awvalid = 1'b1;
        while (awready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("aw_accept", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (wready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("w_accept", 64'(wready), 64'd1);
        tick();
        wvalid = 1'b0;
    endtask

    // Called right after the second of AW/W handshakes
    task automatic wait_b();
        int n;
        logic [1:0] e;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("b_latency", 64'(n), 64'd1);
        e = (q_bresp.size() != 0) ? q_bresp.pop_front() : 2'bxx;
        chk("bresp", 64'(bresp), 64'(e));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_drop", 64'(bvalid), 64'd0);
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input bit w_first, input logic [1:0] exp_resp);
        q_bresp.push_back(exp_resp);
        if (w_first) begin
            do_w(d, s);
            repeat (lead) tick();
            do_aw(a);
        end else begin
            do_aw(a);
            repeat (lead) tick();
            do_w(d, s);
        end
        wait_b();
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] exp_d,
                            input logic [1:0] exp_r, input int hold);
        int n;
        logic [33:0] e;
        n = 0;
        q_rd.push_back({exp_r, exp_d});
        araddr  = a;
        arvalid = 1'b1;
        while (arready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ar_accept", 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        chk("r_early", 64'(rvalid), 64'd0);
        tick();
        chk("r_latency", 64'(rvalid), 64'd1);
        e = (q_rd.size() != 0) ? q_rd.pop_front() : 34'bx;
        chk("rdata", 64'(rdata), 64'(e[31:0]));
        chk("rresp", 64'(rresp), 64'(e[33:32]));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("r_hold_valid", 64'(rvalid), 64'd1);
            chk("r_hold_data", 64'(rdata), 64'(e[31:0]));
            chk("ar_blocked", 64'(arready), 64'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_drop", 64'(rvalid), 64'd0);
        chk("ar_reopen", 64'(arready), 64'd1);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        decouple_done = '0;
        decouple_status_vector = '0;
        oversize_error_irq = '0;
        timeout_error_irq = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_readies", 64'({awready, wready, arready}), 64'd0);
        chk("rst_valids", 64'({bvalid, rvalid, irq}), 64'd0);
        chk("rst_rdata", 64'({rdata, rresp, bresp}), 64'd0);
        chk("rst_ctrl", 64'({decouple, oversize_error_clear, timeout_error_clear}), 64'd0);
        chk("rst_init", 64'(init_token), 64'd0);
        chk("rst_upd", 64'(upd_token), 64'd0);
        areset = 1'b0;
        tick();
        chk("post_rst_readies", 64'({awready, wready, arready}), 64'h7);

        // Decouple write on ch1 with AW leading W by three cycles
        axi_write(12'h010, 32'h1, 4'hF, 3, 1'b0, 2'b00);
        chk("decouple_ch1", 64'(decouple), 64'b0010);
        decouple_done = 4'b0010;
        decouple_status_vector = 8'h0C;
        axi_read(12'h010, 32'h0000_000F, 2'b00, 0);

        // Byte-strobed INIT on ch2, UPD on ch2 with W leading AW
        axi_write(12'h028, 32'h1234, 4'hF, 0, 1'b0, 2'b00);
        axi_write(12'h028, 32'hABCD, 4'b0001, 1, 1'b0, 2'b00);
        chk("init_ch2_strb", 64'(init_token[2*INT_W +: INT_W]), 64'h12CD);
        axi_read(12'h028, 32'h0000_12CD, 2'b00, 0);
        axi_write(12'h02C, 32'hFFFF_FFFF, 4'hF, 2, 1'b1, 2'b00);
        chk("upd_ch2", 64'(upd_token[2*UPD_W +: UPD_W]), 64'h1FF);
        axi_read(12'h02C, 32'h0000_01FF, 2'b00, 0);

        // Timeout sticky and irq on ch1, then W1C
        axi_write(12'h014, 32'h20, 4'h1, 0, 1'b0, 2'b00);
        chk("irq_idle", 64'(irq), 64'd0);
        timeout_error_irq = 4'b0010;
        tick();
        timeout_error_irq = 4'b0000;
        tick();
        chk("irq_set", 64'(irq), 64'd1);
        axi_read(12'h014, 32'h0000_0028, 2'b00, 0);
        axi_write(12'h014, 32'h28, 4'h1, 0, 1'b0, 2'b00);
        chk("irq_cleared", 64'(irq), 64'd0);
        axi_read(12'h014, 32'h0000_0020, 2'b00, 0);

        // W1C loses to a live raw condition; clear pulse is one cycle wide
        timeout_error_irq = 4'b0001;
        tick();
        axi_write(12'h004, 32'h08, 4'h1, 0, 1'b0, 2'b00);
        axi_read(12'h004, 32'h0000_0088, 2'b00, 0);
        chk("irq_not_enabled", 64'(irq), 64'd0);
        timeout_error_irq = 4'b0000;
        tick();
        clr_snap = clr_cycles;
        axi_write(12'h004, 32'h0B, 4'h1, 0, 1'b0, 2'b00);
        chk("tmo_clear_cycles", 64'(clr_cycles - clr_snap), 64'd1);
        chk("tmo_clear_mask", 64'(clr_mask), 64'b0001);
        chk("ovs_clear_level", 64'(oversize_error_clear), 64'b0001);
        axi_read(12'h004, 32'h0000_0001, 2'b00, 0);

        // Unmapped accesses and the ID register
        axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 2'b10);
        chk("unmapped_decouple", 64'(decouple), 64'b0010);
        chk("unmapped_init", 64'(init_token), 64'h0000_12CD_0000_0000);
        chk("unmapped_upd", 64'(upd_token), 64'(36'h1FF) << 18);
        axi_read(12'h044, 32'h0, 2'b10, 0);
        axi_read(12'hFFC, 32'h4E49_0204, 2'b00, 0);

        // Read back-pressure
        axi_read(12'h028, 32'h0000_12CD, 2'b00, 5);

        // Reset with only W buffered: nothing may commit afterwards
        do_w(32'h55AA, 4'hF);
        #3 areset = 1'b1;
        #1;
        chk("mid_rst_readies", 64'({awready, wready, arready}), 64'd0);
        chk("mid_rst_valids", 64'({bvalid, rvalid, irq}), 64'd0);
        chk("mid_rst_ctrl", 64'({decouple, oversize_error_clear, timeout_error_clear}), 64'd0);
        chk("mid_rst_tokens", 64'({init_token, upd_token} != '0), 64'd0);
        tick();
        tick();
        areset = 1'b0;
        tick();
        chk("rel_readies", 64'({awready, wready}), 64'h3);
        do_aw(12'h008);
        repeat (3) tick();
        chk("no_partial_commit_b", 64'(bvalid), 64'd0);
        chk("no_partial_commit_init", 64'(init_token), 64'd0);
        q_bresp.push_back(2'b00);
        do_w(32'h0777, 4'hF);
        wait_b();
        chk("init_ch0_after_rst", 64'(init_token[0 +: INT_W]), 64'h0777);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
